ad9648_init_sequencer: RTL
==========================

# ad9648_init_sequencer

Power-up configuration sequencer for the AD9648 dual ADC, in the system clock domain directly upstream of the low-level controller's SPI port. It drives `start_transfer`/`tx_data` and consumes `transfer_done`/`rx_data` from that port. It verifies the chip ID, writes a fixed register table, commits the table with a transfer-register write, and then asserts `config_done_o`. The controller's `config_done_i` takes `config_done_o` directly.

## Interface
- `TxRegWidth`, 24: SPI frame width. Frame layout is [23] R/W (1 = read), [22:21] W1:W0 = 00, [20:8] address, [7:0] data.
- `RxRegWidth`, 8: readback width.
- `PwrUpCycles`, 1000: wait after reset or restart before the first transfer.
- `TimeoutCycles`, 4096: maximum cycles from issuing a transfer to `transfer_done_i`.
- `ChipId`, 8'h88: expected value of register 0x001.
- `MaxRetries`, 3: extra chip-ID read attempts allowed after a mismatch.

Ports:
- `clk_sys_i`, in, 1: system clock.
- `rst_sys_clk_i`, in, 1: reset. Asynchronous, active-high.
- `restart_i`, in, 1: one-cycle pulse that re-runs the sequence. Honoured only in DONE or ERROR.
- `start_transfer_o`, out, 1: one-cycle pulse that starts a controller SPI frame.
- `tx_data_o`, out, TxRegWidth: frame for the controller. Held stable from issue until `transfer_done_i`.
- `transfer_done_i`, in, 1: one-cycle completion pulse from the controller.
- `rx_data_i`, in, RxRegWidth: read data. Valid in the cycle `transfer_done_i` is high.
- `config_done_o`, out, 1: high in DONE only.
- `busy_o`, out, 1: high in every state except IDLE, DONE and ERROR.
- `error_o`, out, 1: high in ERROR only.
- `error_code_o`, out, 2: 00 none, 01 chip-ID mismatch, 10 timeout, 11 readback mismatch.
- `chip_id_o`, out, 8: last chip ID read.
- `step_o`, out, 3: index of the current table entry.

## Operation
- Reset values: every output is 0. Internal counters are 0 and the state is IDLE.
- The state after reset release and after `restart_i` is the same. From IDLE the FSM moves to PWR_WAIT on the next cycle; no start input is needed.
- States:
  - PWR_WAIT: count `PwrUpCycles`, then go to ID_RD.
  - ID_RD: issue a read of 0x001 (frame 24'h80_01_00 with R/W = 1 and address 0x001), then wait.
  - ID_CHK: compare the captured data to `ChipId`.
    - Match: go to WR with `step_o` = 0.
    - Mismatch with retry count < `MaxRetries`: increment the retry count and return to ID_RD.
    - Otherwise: go to ERROR with code 01.
  - WR: issue the write for table[`step_o`], then wait. After completion, go to WR_RB when `AD9648_INIT_READBACK_EN` is defined. Otherwise advance.
  - Advance: increment `step_o`. After the last entry, go to COMMIT; otherwise return to WR.
  - COMMIT: write 0x0FF = 0x01 (transfer bit), wait, then go to DONE.
  - DONE: hold `config_done_o` high. On `restart_i`, clear status and go to PWR_WAIT.
  - ERROR: hold `error_o` and `error_code_o`. On `restart_i`, clear status and go to PWR_WAIT.
- Register table, fixed and 4 entries, written in this order:
  1. 0x005 = 0x03 (both channels).
  2. 0x008 = 0x00 (normal power).
  3. 0x014 = 0x01 (two's complement output).
  4. 0x016 = 0x00 (default DCO phase).
- Each wait has its own timeout counter. The counter clears on issue. If it reaches `TimeoutCycles` without `transfer_done_i`, go to ERROR with code 10.
- `transfer_done_i` outside a wait state is ignored.
- `restart_i` while busy is ignored.
- `rx_data_i` is captured only in a read wait.
- The retry count clears on entry to PWR_WAIT.

## Timing
- The first `start_transfer_o` fires exactly `PwrUpCycles` + 2 cycles after reset deassertion.
- `start_transfer_o` rises in the same cycle `tx_data_o` takes the new frame.
- Turnaround: the next issue comes no earlier than 2 cycles after a `transfer_done_i` (1 cycle evaluate, 1 cycle issue).
- `config_done_o` rises 1 cycle after the COMMIT `transfer_done_i`.
- Asynchronous reset mid-transfer forces IDLE immediately. `start_transfer_o` is not re-pulsed for the aborted frame.
- A timeout taken in the same cycle as `transfer_done_i` resolves in favour of `transfer_done_i`.

## Configuration
- `AD9648_INIT_READBACK_EN` defined: after each table write, issue a read of the same address (R/W = 1, data 0x00) and compare the result to the written value. A mismatch goes to ERROR with code 11. There are 4 extra transfers.
- `AD9648_INIT_READBACK_EN` undefined: the WR_RB state and its compare logic are absent. Code 11 is never produced.

## Test plan
- Nominal: responder returns 0x88 with `transfer_done_i` 20 cycles after each start. Required: 6 frames (ID read, 4 writes, commit 24'h00_FF_01), then `config_done_o` = 1 and `error_o` = 0.
- ID mismatch: responder returns 0x00 always. Required: 4 ID reads, then `error_code_o` = 01, `chip_id_o` = 0x00, and no write frames.
- Timeout: responder never pulses done. Required: `error_code_o` = 10 exactly `TimeoutCycles` cycles after the first issue, with `busy_o` = 0.
- Readback (macro defined): readback of 0x014 returns 0x00. Required: `error_code_o` = 11 and `step_o` = 2.
- Reset mid-write: `rst_sys_clk_i` asserted during step 1. Required: all outputs 0 immediately. After release, the sequence restarts from PWR_WAIT.
- Restart: `restart_i` pulse in DONE. Required: `config_done_o` = 0 next cycle, then a full 6-frame sequence. A `restart_i` pulse while `busy_o` = 1 has no effect.

Source files
------------

// File: rtl/ad9648_init_sequencer.sv
// AD9648 power-up sequencer: chip-ID check, fixed register table write, transfer-register commit.
// Optional build macro AD9648_INIT_READBACK_EN adds a verifying read after every table write.
module ad9648_init_sequencer #(
   parameter int         TxRegWidth    = 24,
   parameter int         RxRegWidth    = 8,
   parameter int         PwrUpCycles   = 1000,
   parameter int         TimeoutCycles = 4096,
   parameter logic [7:0] ChipId        = 8'h88,
   parameter int         MaxRetries    = 3
) (
   input  logic                  clk_sys_i,
   input  logic                  rst_sys_clk_i,
   input  logic                  restart_i,
   output logic                  start_transfer_o,
   output logic [TxRegWidth-1:0] tx_data_o,
   input  logic                  transfer_done_i,
   input  logic [RxRegWidth-1:0] rx_data_i,
   output logic                  config_done_o,
   output logic                  busy_o,
   output logic                  error_o,
   output logic [1:0]            error_code_o,
   output logic [7:0]            chip_id_o,
   output logic [2:0]            step_o
);

   localparam int PwrW = $clog2(PwrUpCycles + 1);
   localparam int TmoW = $clog2(TimeoutCycles + 1);
   localparam logic [PwrW-1:0] PWR_LAST  = PwrW'(PwrUpCycles - 1);
   localparam logic [TmoW-1:0] TMO_LAST  = TmoW'(TimeoutCycles - 1);
   localparam logic [7:0]      RETRY_MAX = 8'(MaxRetries);
   localparam logic [12:0]     ID_ADDR   = 13'h001;
   localparam logic [12:0]     XFER_ADDR = 13'h0FF;
   localparam logic [12:0]     TBL_ADDR [4] = '{13'h005, 13'h008, 13'h014, 13'h016};
   localparam logic [7:0]      TBL_DATA [4] = '{8'h03, 8'h00, 8'h01, 8'h00};

   typedef enum logic [3:0] {
      S_IDLE,
      S_PWR_WAIT,
      S_ID_RD,
      S_ID_CHK,
      S_WR,
      S_ADVANCE,
`ifdef AD9648_INIT_READBACK_EN
      S_WR_RB,
      S_RB_CHK,
`endif
      S_COMMIT,
      S_XFER_WAIT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                  state;
   state_t                  wait_nxt;
   state_t                  issue_nxt;
   logic [TxRegWidth-1:0]   issue_frame;
   logic [PwrW-1:0]         pwr_cnt;
   logic [TmoW-1:0]         tmo_cnt;
   logic [7:0]              retry_cnt;
   logic [1:0]              tbl_idx;
`ifdef AD9648_INIT_READBACK_EN
   logic [7:0]              rb_q;
`endif

   assign tbl_idx = step_o[1:0];

   function automatic logic [TxRegWidth-1:0] frame(input logic rd, input logic [12:0] addr,
                                                   input logic [7:0] data);
      return TxRegWidth'({rd, 2'b00, addr, data});
   endfunction

   // Frame and post-completion state for whichever issue state is active.
   always_comb begin
      issue_frame = frame(1'b1, ID_ADDR, 8'h00);
      issue_nxt   = S_ID_CHK;
      case (state)
         S_WR: begin
            issue_frame = frame(1'b0, TBL_ADDR[tbl_idx], TBL_DATA[tbl_idx]);
`ifdef AD9648_INIT_READBACK_EN
            issue_nxt   = S_WR_RB;
`else
            issue_nxt   = S_ADVANCE;
`endif
         end
`ifdef AD9648_INIT_READBACK_EN
         S_WR_RB: begin
            issue_frame = frame(1'b1, TBL_ADDR[tbl_idx], 8'h00);
            issue_nxt   = S_RB_CHK;
         end
`endif
         S_COMMIT: begin
            issue_frame = frame(1'b0, XFER_ADDR, 8'h01);
            issue_nxt   = S_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys_i or posedge rst_sys_clk_i) begin
      if (rst_sys_clk_i) begin
         state            <= S_IDLE;
         wait_nxt         <= S_IDLE;
         pwr_cnt          <= '0;
         tmo_cnt          <= '0;
         retry_cnt        <= '0;
         start_transfer_o <= 1'b0;
         tx_data_o        <= '0;
         config_done_o    <= 1'b0;
         busy_o           <= 1'b0;
         error_o          <= 1'b0;
         error_code_o     <= 2'b00;
         chip_id_o        <= 8'h00;
         step_o           <= 3'd0;
`ifdef AD9648_INIT_READBACK_EN
         rb_q             <= 8'h00;
`endif
      end else begin
         start_transfer_o <= 1'b0;
         case (state)
            // IDLE always starts; DONE/ERROR start again only on restart.
            S_IDLE, S_DONE, S_ERROR: begin
               if (state == S_IDLE || restart_i) begin
                  state         <= S_PWR_WAIT;
                  pwr_cnt       <= '0;
                  retry_cnt     <= '0;
                  step_o        <= 3'd0;
                  busy_o        <= 1'b1;
                  config_done_o <= 1'b0;
                  error_o       <= 1'b0;
                  error_code_o  <= 2'b00;
               end
            end
            S_PWR_WAIT: begin
               if (pwr_cnt == PWR_LAST) state <= S_ID_RD;
               else                     pwr_cnt <= pwr_cnt + 1'b1;
            end
`ifdef AD9648_INIT_READBACK_EN
            S_ID_RD, S_WR, S_WR_RB, S_COMMIT: begin
`else
            S_ID_RD, S_WR, S_COMMIT: begin
`endif
               start_transfer_o <= 1'b1;
               tx_data_o        <= issue_frame;
               tmo_cnt          <= '0;
               wait_nxt         <= issue_nxt;
               state            <= S_XFER_WAIT;
            end
            // Completion takes priority over a timeout landing on the same cycle.
            S_XFER_WAIT: begin
               if (transfer_done_i) begin
                  state <= wait_nxt;
                  if (wait_nxt == S_ID_CHK) chip_id_o <= 8'(rx_data_i);
`ifdef AD9648_INIT_READBACK_EN
                  if (wait_nxt == S_RB_CHK) rb_q <= 8'(rx_data_i);
`endif
                  if (wait_nxt == S_DONE) begin
                     busy_o        <= 1'b0;
                     config_done_o <= 1'b1;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state        <= S_ERROR;
                  busy_o       <= 1'b0;
                  error_o      <= 1'b1;
                  error_code_o <= 2'b10;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_ID_CHK: begin
               if (chip_id_o == ChipId) begin
                  state  <= S_WR;
                  step_o <= 3'd0;
               end else if (retry_cnt < RETRY_MAX) begin
                  retry_cnt <= retry_cnt + 8'd1;
                  state     <= S_ID_RD;
               end else begin
                  state        <= S_ERROR;
                  busy_o       <= 1'b0;
                  error_o      <= 1'b1;
                  error_code_o <= 2'b01;
               end
            end
`ifdef AD9648_INIT_READBACK_EN
            S_RB_CHK: begin
               if (rb_q == TBL_DATA[tbl_idx]) begin
                  state <= S_ADVANCE;
               end else begin
                  state        <= S_ERROR;
                  busy_o       <= 1'b0;
                  error_o      <= 1'b1;
                  error_code_o <= 2'b11;
               end
            end
`endif
            S_ADVANCE: begin
               step_o <= step_o + 3'd1;
               state  <= (step_o == 3'd3) ? S_COMMIT : S_WR;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
